fwd_ctrl: RTL and testbench
===========================

# fwd_ctrl

Forwarding and load-use hazard controller for the 5-stage pipeline. It shadows destination-register tags of in-flight instructions (EX, MEM, WB). It produces registered 2-bit selects for the two EX-stage operand 3-input data muxes (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result) and a one-cycle load-use stall toward the PC and IF/ID registers. It sits upstream of the EX operand muxes, alongside the ID/EX pipeline register.

## Interface
Parameters:
- REG_W, 5: register index width; matches the register-index mux.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs, id_rt  in  REG_W  source register indices of the ID instruction.
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt.
- id_rd  in  REG_W  destination index, already chosen by the destination-register mux.
- id_reg_write  in  1  the ID instruction writes the register file.
- id_mem_read  in  1  the ID instruction is a load.
- flush  in  1  taken branch/jump; the ID instruction is killed this cycle.
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble into ID/EX.
- fwd_sel_a, fwd_sel_b  out  2  registered selects for the EX operand A/B muxes.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

## Operation
- Three tag registers, ex_t, mem_t and wb_t, each hold {valid, rd, reg_write, mem_read}. Every clock they shift: wb_t <= mem_t, mem_t <= ex_t, ex_t <= new entry.
- New entry:
  - ID fields with valid = id_valid, when neither stall nor flush is asserted.
  - A bubble (all fields 0), when stall or flush is asserted.
- A tag is a writer of register r when: valid & reg_write & rd == r & r != 0.
- Load-use stall: stall = id_valid & !flush & ex_t.valid & ex_t.mem_read & ex_t.rd != 0, and (id_use_rs & id_rs == ex_t.rd, or id_use_rt & id_rt == ex_t.rd).
- Select for operand A, computed in ID and registered into fwd_sel_a at the advancing edge:
  - 1 if id_use_rs and ex_t is a writer of id_rs and ex_t is not a load. ex_t will be in MEM when this instruction is in EX.
  - otherwise 2 if id_use_rs and mem_t is a writer of id_rs. mem_t will be in WB.
  - otherwise 0.
- Operand B is computed the same way from id_use_rt / id_rt.
- The younger producer has priority, so a hit on 1 beats a hit on 2.
- Select registers load 0 on any cycle where stall, flush or !id_valid holds, so a bubble always reads the register file.
- The WB-to-ID same-cycle case is not forwarded. The register file writes in the first half-cycle, so the select is 0.
- Register 0 is never forwarded.
- stall_cnt increments by 1 on each clock where stall = 1 and saturates at 2^CNT_W - 1.

## Timing
- Reset (rst_n low, asynchronous): all tags invalid and zero, fwd_sel_a = fwd_sel_b = 0, stall_cnt = 0. Stall is therefore 0 while in reset.
- Select latency: one clock. The select is computed while the instruction is in ID and is valid during its EX cycle.
- Load-use: exactly one stall cycle per dependent load.
  - Next cycle the load is in mem_t and the dependent re-evaluates to select 2.
  - A second stall for the same pair is an error.
- flush and stall in the same cycle: flush wins. stall = 0, a bubble is inserted, and the counter does not increment.
- A reset deasserted mid-stream discards all tags. The first instruction after reset gets select 0.
- There is no global freeze input; tags advance every clock.

## Test plan
- ALU writer r5 followed immediately by a reader of r5 on rs: fwd_sel_a = 1 in the reader's EX cycle, stall = 0.
- Writer r5, one unrelated instruction, then a reader of r5 on rt: fwd_sel_b = 2.
- Writer r5, writer r5, then a reader of r5 on both operands: fwd_sel_a = fwd_sel_b = 1 (younger wins).
- Load r7 followed immediately by a reader of r7: stall = 1 for exactly one cycle. The next cycle gives a bubble in EX with select 0, then the reader's EX cycle has select 2, and stall_cnt = 1.
- Load r7 plus a dependent with flush = 1 in the same cycle: stall = 0, a bubble in EX, stall_cnt unchanged.
- A writer with rd = 0, or a reader with id_use_rs = 0 and a matching index, gives select 0. Asserting rst_n = 0 mid-stream clears selects and stall_cnt immediately.

Source files
------------

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: operand forwarding select and load-use stall generator.
// Tracks destination tags of instructions in EX, MEM and WB.
module fwd_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } tag_t;

    tag_t ex_t;
    tag_t mem_t;
    tag_t wb_t;
    tag_t new_t;

    logic [1:0] sel_a_nxt;
    logic [1:0] sel_b_nxt;
    logic       kill;

    function automatic logic writes(
        input tag_t             t,
        input logic [REG_W-1:0] r
    );
        return t.valid && t.reg_write &&
               (t.rd == r) && (r != '0);
    endfunction

    // Younger producer (EX, not a load) beats older one (MEM).
    function automatic logic [1:0] pick(
        input tag_t             ex,
        input tag_t             mem,
        input logic             use_r,
        input logic [REG_W-1:0] r
    );
        logic [1:0] s;
        s = 2'd0;
        if (use_r && writes(ex, r) && !ex.mem_read)
            s = 2'd1;
        else if (use_r && writes(mem, r))
            s = 2'd2;
        return s;
    endfunction

    // Load-use detection and next-cycle operand selects.
    always_comb begin
        stall = 1'b0;
        if (id_valid && !flush && ex_t.valid &&
            ex_t.mem_read && (ex_t.rd != '0)) begin
            stall = (id_use_rs && (id_rs == ex_t.rd)) ||
                    (id_use_rt && (id_rt == ex_t.rd));
        end
        kill      = stall || flush || !id_valid;
        sel_a_nxt = pick(ex_t, mem_t, id_use_rs, id_rs);
        sel_b_nxt = pick(ex_t, mem_t, id_use_rt, id_rt);
        new_t     = '0;
        if (!kill) begin
            new_t.valid     = 1'b1;
            new_t.rd        = id_rd;
            new_t.reg_write = id_reg_write;
            new_t.mem_read  = id_mem_read;
        end
    end

    // Tag shift register; advances every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_t  <= '0;
            mem_t <= '0;
            wb_t  <= '0;
        end else begin
            ex_t  <= new_t;
            mem_t <= ex_t;
            wb_t  <= mem_t;
        end
    end

    // Registered selects; bubbles always read the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_a <= 2'd0;
            fwd_sel_b <= 2'd0;
        end else if (kill) begin
            fwd_sel_a <= 2'd0;
            fwd_sel_b <= 2'd0;
        end else begin
            fwd_sel_a <= sel_a_nxt;
            fwd_sel_b <= sel_b_nxt;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

    a_bubble_zero: assert property (
        @(posedge clk) disable iff (!rst_n)
        !wb_t.valid |-> (wb_t == '0));

    a_single_stall: assert property (
        @(posedge clk) disable iff (!rst_n)
        stall |=> !stall);

endmodule

// File: tb/tb_fwd_ctrl.sv
// tb_fwd_ctrl: directed vector table, reset corner case and
// randomized run against an instruction-history reference model.
module tb_fwd_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_sel_a;
    logic [1:0]       fwd_sel_b;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       ut;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       fl;
        logic       est;
        logic [1:0] ea;
        logic [1:0] eb;
        int         ecnt;
    } vec_t;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ent_t;

    vec_t vt[28];
    ent_t hist[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic ur, input logic ut, input logic [4:0] rd,
        input logic rw, input logic mr, input logic fl,
        input logic est, input logic [1:0] ea, input logic [1:0] eb,
        input int ecnt);
        vec_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.ur = ur; x.ut = ut;
        x.rd = rd; x.rw = rw; x.mr = mr; x.fl = fl;
        x.est = est; x.ea = ea; x.eb = eb; x.ecnt = ecnt;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        id_valid     = x.v;
        id_rs        = x.rs;
        id_rt        = x.rt;
        id_use_rs    = x.ur;
        id_use_rt    = x.ut;
        id_rd        = x.rd;
        id_reg_write = x.rw;
        id_mem_read  = x.mr;
        flush        = x.fl;
    endtask

    // Drive one ID cycle, check stall, clock, check registered outputs.
    task automatic step(input vec_t x, input string tag);
        drive(x);
        #1;
        chk({tag, ".stall"}, int'(stall), int'(x.est));
        @(posedge clk);
        #1;
        chk({tag, ".sel_a"}, int'(fwd_sel_a), int'(x.ea));
        chk({tag, ".sel_b"}, int'(fwd_sel_b), int'(x.eb));
        chk({tag, ".cnt"}, int'(stall_cnt), x.ecnt);
    endtask

    function automatic bit writes(input ent_t e, input logic [4:0] r);
        return e.v && e.rw && (e.rd == r) && (r != 0);
    endfunction

    initial begin
        vec_t nop;
        nop = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
        drive(nop);
        rst_n = 1'b0;
        #12;
        chk("reset.stall", int'(stall), 0);
        chk("reset.sel_a", int'(fwd_sel_a), 0);
        chk("reset.sel_b", int'(fwd_sel_b), 0);
        chk("reset.cnt", int'(stall_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vt[0]  = mk(1,0,0,0,0,5,1,0,0, 0,0,0,0);
        vt[1]  = mk(1,5,0,1,0,0,0,0,0, 0,1,0,0);
        vt[2]  = mk(1,0,0,0,0,5,1,0,0, 0,0,0,0);
        vt[3]  = mk(1,1,2,1,1,9,1,0,0, 0,0,0,0);
        vt[4]  = mk(1,0,5,0,1,0,0,0,0, 0,0,2,0);
        vt[5]  = mk(1,0,0,0,0,5,1,0,0, 0,0,0,0);
        vt[6]  = mk(1,0,0,0,0,5,1,0,0, 0,0,0,0);
        vt[7]  = mk(1,5,5,1,1,0,0,0,0, 0,1,1,0);
        vt[8]  = mk(1,0,0,0,0,7,1,1,0, 0,0,0,0);
        vt[9]  = mk(1,7,0,1,0,0,0,0,0, 1,0,0,1);
        vt[10] = mk(1,7,0,1,0,0,0,0,0, 0,2,0,1);
        vt[11] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,1);
        vt[12] = mk(1,0,0,0,0,7,1,1,0, 0,0,0,1);
        vt[13] = mk(1,7,0,1,0,0,0,0,1, 0,0,0,1);
        vt[14] = mk(1,7,0,1,0,0,0,0,0, 0,2,0,1);
        vt[15] = mk(1,0,0,0,0,0,1,0,0, 0,0,0,1);
        vt[16] = mk(1,0,0,1,1,0,0,0,0, 0,0,0,1);
        vt[17] = mk(1,0,0,0,0,3,1,0,0, 0,0,0,1);
        vt[18] = mk(1,3,3,0,1,0,0,0,0, 0,0,1,1);
        vt[19] = mk(1,0,0,0,0,4,1,1,0, 0,0,0,1);
        vt[20] = mk(1,4,4,0,0,0,0,0,0, 0,0,0,1);
        vt[21] = mk(1,0,0,0,0,6,1,0,0, 0,0,0,1);
        vt[22] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,1);
        vt[23] = mk(0,0,0,0,0,0,0,0,0, 0,0,0,1);
        vt[24] = mk(1,6,6,1,1,0,0,0,0, 0,0,0,1);
        vt[25] = mk(1,0,0,0,0,8,1,1,0, 0,0,0,1);
        vt[26] = mk(1,0,0,0,0,0,0,0,0, 0,0,0,1);
        vt[27] = mk(1,0,8,0,1,0,0,0,0, 0,0,2,1);

        for (int i = 0; i < 28; i++)
            step(vt[i], $sformatf("vec%0d", i));

        // Mid-stream asynchronous reset.
        step(mk(1,0,0,0,0,5,1,0,0, 0,0,0,1), "rst.w5");
        step(mk(1,0,0,0,0,7,1,1,0, 0,0,0,1), "rst.ld7");
        step(mk(1,7,0,1,0,0,0,0,0, 1,0,0,2), "rst.use7");
        step(mk(1,0,0,0,0,5,1,0,0, 0,0,0,2), "rst.w5b");
        step(mk(1,5,0,1,0,0,0,0,0, 0,1,0,2), "rst.use5");
        drive(mk(1,5,0,1,0,0,0,0,0, 0,0,0,0));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst.async.sel_a", int'(fwd_sel_a), 0);
        chk("rst.async.cnt", int'(stall_cnt), 0);
        chk("rst.async.stall", int'(stall), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(mk(1,5,0,1,0,0,0,0,0, 0,0,0,0), "rst.first");

        // Randomized run against the history model.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(nop);
        #2;
        rst_n = 1'b1;
        hist.delete();
        begin
            ent_t b;
            int   mcnt;
            b = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
            hist.push_front(b);
            hist.push_front(b);
            mcnt = 0;
            for (int n = 0; n < 1500; n++) begin
                vec_t x;
                ent_t e;
                ent_t p1;
                ent_t p2;
                bit   es;
                int   ea;
                int   eb;
                x.v  = ($urandom_range(0, 99) < 85);
                x.rs = 5'($urandom_range(0, 3));
                x.rt = 5'($urandom_range(0, 3));
                x.ur = 1'($urandom);
                x.ut = 1'($urandom);
                x.rd = 5'($urandom_range(0, 3));
                x.rw = ($urandom_range(0, 99) < 70);
                x.mr = ($urandom_range(0, 99) < 30);
                x.fl = ($urandom_range(0, 99) < 10);
                p1 = hist[0];
                p2 = hist[1];
                es = x.v && !x.fl && p1.v && p1.mr && (p1.rd != 0) &&
                     ((x.ur && x.rs == p1.rd) ||
                      (x.ut && x.rt == p1.rd));
                ea = 0;
                eb = 0;
                if (x.v && !x.fl && !es) begin
                    if (x.ur && writes(p1, x.rs) && !p1.mr) ea = 1;
                    else if (x.ur && writes(p2, x.rs)) ea = 2;
                    if (x.ut && writes(p1, x.rt) && !p1.mr) eb = 1;
                    else if (x.ut && writes(p2, x.rt)) eb = 2;
                end
                if (es && mcnt < (1 << CNT_W) - 1) mcnt++;
                e = b;
                if (x.v && !x.fl && !es)
                    e = '{v: 1'b1, rd: x.rd, rw: x.rw, mr: x.mr};
                hist.push_front(e);
                hist.pop_back();
                x.est  = es;
                x.ea   = 2'(ea);
                x.eb   = 2'(eb);
                x.ecnt = mcnt;
                step(x, $sformatf("rnd%0d", n));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
